// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream multiplexer: grant-mode encodings and the width of the optional transfer counter.
// No logic and no latency; constants only.
// No flow control; the constants are used by stream_mux and its testbench.
package stream_mux_pkg;

    localparam logic MODE_SEL   = 1'b0;  // grant the channel named by sel
    localparam logic MODE_RR    = 1'b1;  // round-robin among valid channels
    localparam int   XFER_CNT_W = 16;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin search: grants the first requester found scanning upward from ptr+1, wrapping past NUM_CH-1 to 0.
// Purely combinational (0 cycles).
// No flow control; it only reports a one-hot grant, which is all zeros when nothing requests.
// Ports: req (per-channel request), ptr (last granted index), grant (one-hot), idx (binary index of grant).
module rr_arbiter #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  idx
);

    logic             found;
    logic [SEL_W-1:0] cand;

    // Offsets 1..NUM_CH visit every channel once, and the last one visited is ptr itself,
    // so the channel that was just served has the lowest priority.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = SEL_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N:1 stream multiplexer with a single output register, using either explicit-select or round-robin arbitration.
// Latency: 1 cycle from an input transfer to out_valid. The mux sustains one transfer per cycle with no bubbles.
// Backpressure: when the register is full and out_ready=0, the outputs hold and every in_ready is 0.
// Ports: in_data/in_valid/in_ready are the per-channel inputs. mode selects the arbitration (0 = sel, 1 = round-robin).
//        sel is the explicit channel. out_data/out_ch/out_valid/out_ready are the registered output stream.
// Optional: defining STREAM_MUX_XFER_CNT_EN adds xfer_cnt, a saturating count of output transfers.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef STREAM_MUX_XFER_CNT_EN
    ,
    output logic [XFER_CNT_W-1:0]   xfer_cnt
`endif
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [NUM_CH-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              space;
    logic              load;
    logic [WIDTH-1:0]  load_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req    (in_valid),
        .ptr    (rr_ptr),
        .grant  (rr_grant),
        .idx    (rr_idx)
    );

    // In explicit mode the grant ignores in_valid, so in_ready[sel] can be high before
    // the channel presents data. An out-of-range sel grants nothing.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (mode == MODE_RR) begin
            grant     = rr_grant;
            grant_idx = rr_idx;
        end else if (int'(sel) < NUM_CH) begin
            grant[sel] = 1'b1;
            grant_idx  = sel;
        end
    end

    assign space = ~out_valid | out_ready;
    assign load  = space & (|(grant & in_valid));

    // rst_n gates in_ready directly. During reset the register reads as empty, which
    // would otherwise let the explicit grant show as ready.
    assign in_ready = {NUM_CH{space & rst_n}} & grant;

    always_comb begin
        load_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                load_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // The reset value of rr_ptr is the last channel, so the first round-robin search starts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(NUM_CH - 1);
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_ch    <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load && (mode == MODE_RR)) begin
                rr_ptr <= grant_idx;
            end
        end
    end

`ifdef STREAM_MUX_XFER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready && (xfer_cnt != {XFER_CNT_W{1'b1}})) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;

    localparam int WIDTH   = 8;
    localparam int NUM_CH  = 8;
    localparam int SEL_W   = 3;
    localparam int NUM_CH6 = 6;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    logic [NUM_CH6*WIDTH-1:0] in_data6;
    logic [NUM_CH6-1:0]       in_valid6;
    logic [NUM_CH6-1:0]       in_ready6;
    logic [WIDTH-1:0]         out_data6;
    logic [2:0]               out_ch6;
    logic                     out_valid6;

`ifdef STREAM_MUX_XFER_CNT_EN
    logic [15:0] xfer_cnt;
    logic [15:0] xfer_cnt6;
`endif

    assign in_data6  = in_data[NUM_CH6*WIDTH-1:0];
    assign in_valid6 = in_valid[NUM_CH6-1:0];

    stream_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef STREAM_MUX_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    stream_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data6),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data6),
        .out_ch    (out_ch6),
        .out_valid (out_valid6),
        .out_ready (out_ready)
`ifdef STREAM_MUX_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt6)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int errors;

    // Reference model of the 8-channel instance
    logic       m_full;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;
    int         m_cnt;
    logic [7:0] exp_ready;

    function automatic int model_pick();
        int c;
        if (mode == 1'b0) begin
            return (int'(sel) < NUM_CH) ? int'(sel) : -1;
        end
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_ptr + k) % NUM_CH;
            if (in_valid[3'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_data = 8'h00;
        m_ch   = 0;
        m_ptr  = NUM_CH - 1;
        m_cnt  = 0;
    endtask

    // Let the inputs settle, then compute the expected in_ready
    task automatic step_pre();
        int  p;
        logic space;
        #1;
        p = model_pick();
        space = !m_full || out_ready;
        exp_ready = (space && p >= 0) ? (8'd1 << p) : 8'd0;
    endtask

    // Advance the model across the next rising edge, then return 1 time unit after it
    task automatic step_edge();
        int  p;
        logic space, load, xfer;
        p = model_pick();
        space = !m_full || out_ready;
        load = space && (p >= 0) && in_valid[3'(p)];
        xfer = m_full && out_ready;
        if (xfer && m_cnt < 65535) m_cnt++;
        if (load) begin
            m_data = in_data[p*WIDTH +: WIDTH];
            m_ch   = p;
            m_full = 1'b1;
            if (mode == 1'b1) m_ptr = p;
        end else if (xfer) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = 8'($urandom);
    endtask

    task automatic test_reset();
        mode = 1'b0; sel = 3'd3; in_valid = 8'hFF; out_ready = 1'b1; rand_data();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h ch=%0d expected 0/00/0", out_valid, out_data, out_ch);
        end
        checks++;
        if (in_ready !== 8'h00 || in_ready6 !== 6'h00) begin
            errors++;
            $display("FAIL reset_in_ready: got %b/%b expected all zero", in_ready, in_ready6);
        end
`ifdef STREAM_MUX_XFER_CNT_EN
        checks++;
        if (xfer_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_xfer_cnt: got %h expected 0000", xfer_cnt);
        end
`endif
        do_reset();
    endtask

    task automatic test_explicit();
        do_reset();
        mode = 1'b0; sel = 3'd3; out_ready = 1'b1; in_valid = 8'h08;
        rand_data();
        in_data[3*WIDTH +: WIDTH] = 8'hA5;
        step_pre();
        checks++;
        if (in_ready !== 8'b0000_1000 || in_ready !== exp_ready) begin
            errors++;
            $display("FAIL explicit_ready: got %b expected %b", in_ready, 8'b0000_1000);
        end
        step_edge();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 3'd3) begin
            errors++;
            $display("FAIL explicit_load: got valid=%b data=%h ch=%0d expected 1/a5/3", out_valid, out_data, out_ch);
        end
        in_valid = 8'h00;
        step_pre();
        step_edge();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL explicit_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_rr_sequence();
        do_reset();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rand_data();
            step_pre();
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b expected %b", i, in_ready, exp_ready);
            end
            step_edge();
            checks++;
            if (out_valid !== 1'b1 || int'(out_ch) !== (i % NUM_CH) || out_data !== m_data) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got valid=%b ch=%0d data=%h expected 1/%0d/%h",
                         i, out_valid, out_ch, out_data, i % NUM_CH, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0; sel = 3'd0; in_valid = 8'h01; out_ready = 1'b0;
        rand_data();
        in_data[0 +: WIDTH] = 8'h11;
        step_pre();
        step_edge();
        in_data[0 +: WIDTH] = 8'h22;
        for (int i = 0; i < 5; i++) begin
            step_pre();
            checks++;
            if (in_ready !== 8'h00 || exp_ready !== 8'h00) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b expected 00000000", i, in_ready);
            end
            step_edge();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h11) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1/11", i, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        step_pre();
        checks++;
        if (in_ready !== 8'h01) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 00000001", in_ready);
        end
        step_edge();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            errors++;
            $display("FAIL bp_release_data: got valid=%b data=%h expected 1/22", out_valid, out_data);
        end
        in_valid = 8'h00;
        step_pre();
        step_edge();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_sel_out_of_range();
        do_reset();
        mode = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sel = (i % 2 == 0) ? 3'd7 : 3'd6;
            rand_data();
            #1;
            checks++;
            if (in_ready6 !== 6'b000000) begin
                errors++;
                $display("FAIL oob_ready[%0d]: got %b expected 000000", i, in_ready6);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid6 !== 1'b0) begin
                errors++;
                $display("FAIL oob_valid[%0d]: got %b expected 0", i, out_valid6);
            end
        end
        sel = 3'd5;
        #1;
        checks++;
        if (in_ready6 !== 6'b100000) begin
            errors++;
            $display("FAIL sel_last_ready: got %b expected 100000", in_ready6);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid6 !== 1'b1 || out_ch6 !== 3'd5 || out_data6 !== in_data[5*WIDTH +: WIDTH]) begin
            errors++;
            $display("FAIL sel_last_load: got valid=%b ch=%0d expected 1/5", out_valid6, out_ch6);
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step_pre();
            step_edge();
        end
        out_ready = 1'b0;
        step_pre();
        step_edge();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got valid=%b ready=%b expected 0/00000000", out_valid, in_ready);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode = 1'b1; in_valid = 8'b0010_0100; out_ready = 1'b1;
        step_pre();
        checks++;
        if (in_ready !== 8'b0000_0100 || exp_ready !== 8'b0000_0100) begin
            errors++;
            $display("FAIL post_reset_ready: got %b expected 00000100", in_ready);
        end
        step_edge();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 3'd2) begin
            errors++;
            $display("FAIL post_reset_first: got valid=%b ch=%0d expected 1/2", out_valid, out_ch);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) mode = 1'($urandom);
            if ($urandom_range(0, 4) == 0) sel = 3'($urandom);
            in_valid  = 8'($urandom) & 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_data();
            step_pre();
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready, exp_ready);
            end
            step_edge();
            checks++;
            if (out_valid !== m_full) begin
                errors++;
                $display("FAIL rand_valid[%0d]: got %b expected %b", i, out_valid, m_full);
            end
            if (m_full) begin
                checks++;
                if (out_data !== m_data || int'(out_ch) !== m_ch) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got data=%h ch=%0d expected %h/%0d",
                             i, out_data, out_ch, m_data, m_ch);
                end
            end
        end
    endtask

`ifdef STREAM_MUX_XFER_CNT_EN
    task automatic test_xfer_cnt();
        do_reset();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 70001; i++) begin
            step_pre();
            step_edge();
            if (i == 10) begin
                checks++;
                if (int'(xfer_cnt) !== m_cnt) begin
                    errors++;
                    $display("FAIL xfer_cnt_early: got %0d expected %0d", xfer_cnt, m_cnt);
                end
            end
        end
        checks++;
        if (xfer_cnt !== 16'hFFFF || m_cnt != 65535) begin
            errors++;
            $display("FAIL xfer_cnt_sat: got %h expected ffff", xfer_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            out_ready = i[0];
            step_pre();
            step_edge();
        end
        checks++;
        if (xfer_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL xfer_cnt_hold: got %h expected ffff", xfer_cnt);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_explicit();
        test_rr_sequence();
        test_backpressure();
        test_sel_out_of_range();
        test_reset_mid_stream();
        test_random();
`ifdef STREAM_MUX_XFER_CNT_EN
        test_xfer_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
